// File: rtl/axi_stream_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_scheduler_pkg
// Description : Shared types for the stream-extractor scheduler: FSM state
//               encoding, slot-table entry layout and a slot-count clamp
//               helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package axi_stream_scheduler_pkg;

  localparam int SCHED_DEST_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    IN_PACKET  = 2'd2,
    ADVANCE    = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [SCHED_DEST_WIDTH-1:0] sel;
    logic [SCHED_DEST_WIDTH-1:0] out_dest;
  } slot_entry_t;

  // A programmed count of 0 still schedules one slot; anything above the
  // table depth is limited to the table depth.
  function automatic int effective_slots(input int requested, input int max_slots);
    if (requested < 1)
      return 1;
    if (requested > max_slots)
      return max_slots;
    return requested;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scheduler_slot_table.sv
`default_nettype none
// ============================================================================
// Module      : scheduler_slot_table
// Description : Register file of N_SLOTS {sel, out_dest} entries with one
//               synchronous write port and one asynchronous read port.
//               Cleared to zero on reset.
// Ports       : clock, reset (sync, active-low), we/waddr/wsel/wout (write),
//               raddr -> rsel/rout (combinational read)
// Revision    : 1.0 - initial release
// ============================================================================
module scheduler_slot_table
  import axi_stream_scheduler_pkg::*;
#(
  parameter int DEST_WIDTH = 8,
  parameter int N_SLOTS    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(N_SLOTS)-1:0] waddr,
  input  logic [DEST_WIDTH-1:0]      wsel,
  input  logic [DEST_WIDTH-1:0]      wout,
  input  logic [$clog2(N_SLOTS)-1:0] raddr,
  output logic [DEST_WIDTH-1:0]      rsel,
  output logic [DEST_WIDTH-1:0]      rout
);

  logic [DEST_WIDTH-1:0] sel_mem [N_SLOTS];
  logic [DEST_WIDTH-1:0] out_mem [N_SLOTS];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        sel_mem[i] <= '0;
        out_mem[i] <= '0;
      end
    end else if (we) begin
      sel_mem[waddr] <= wsel;
      out_mem[waddr] <= wout;
    end
  end

  assign rsel = sel_mem[raddr];
  assign rout = out_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/axi_stream_extractor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_extractor_scheduler
// Description : Drives selector/out_dest of a downstream stream extractor,
//               stepping round-robin through a programmable slot table. Holds
//               a slot until a full packet for its dest is seen on the
//               snooped stream, or skips it after timeout_limit silent cycles.
// Ports       : clock, reset (sync, active-low), enable, n_slots,
//               timeout_limit, cfg_* (table write), mon_* (stream snoop),
//               selector/out_dest/slot_idx/slot_skipped/busy (outputs).
//               With SCHEDULER_STATS_EN defined: stat_addr in,
//               pkt_count/skip_count out (per-slot statistics).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_extractor_scheduler
  import axi_stream_scheduler_pkg::*;
#(
  parameter int DEST_WIDTH    = 8,
  parameter int N_SLOTS       = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [$clog2(N_SLOTS):0]   n_slots,
  input  logic [TIMEOUT_WIDTH-1:0]   timeout_limit,
  input  logic                       cfg_we,
  input  logic [$clog2(N_SLOTS)-1:0] cfg_addr,
  input  logic [DEST_WIDTH-1:0]      cfg_sel,
  input  logic [DEST_WIDTH-1:0]      cfg_out_dest,
  input  logic [DEST_WIDTH-1:0]      mon_dest,
  input  logic                       mon_valid,
  input  logic                       mon_ready,
  input  logic                       mon_tlast,
  output logic [DEST_WIDTH-1:0]      selector,
  output logic [DEST_WIDTH-1:0]      out_dest,
  output logic [$clog2(N_SLOTS)-1:0] slot_idx,
  output logic                       slot_skipped,
  output logic                       busy
`ifdef SCHEDULER_STATS_EN
  ,
  input  logic [$clog2(N_SLOTS)-1:0] stat_addr,
  output logic [31:0]                pkt_count,
  output logic [15:0]                skip_count
`endif
);

  localparam int SW = $clog2(N_SLOTS);

  sched_state_t           state, state_next;
  logic [SW-1:0]          slot_next;
  logic [TIMEOUT_WIDTH-1:0] wait_count;
  logic                   skip_now;
  logic                   match;
  logic                   timeout_hit;
  logic                   last_slot;
  int                     active_slots;
  logic [DEST_WIDTH-1:0]  tbl_sel, tbl_out;
  logic [DEST_WIDTH-1:0]  sel_next, out_next;

  assign match       = mon_valid & mon_ready & (mon_dest == selector);
  assign timeout_hit = (timeout_limit != '0) &&
                       (wait_count >= (timeout_limit - TIMEOUT_WIDTH'(1)));

  always_comb begin
    active_slots = effective_slots(int'(n_slots), N_SLOTS);
    last_slot    = ((int'(slot_idx) + 1) >= active_slots);
  end

  scheduler_slot_table #(
    .DEST_WIDTH (DEST_WIDTH),
    .N_SLOTS    (N_SLOTS)
  ) u_table (
    .clock (clock),
    .reset (reset),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wsel  (cfg_sel),
    .wout  (cfg_out_dest),
    .raddr (slot_next),
    .rsel  (tbl_sel),
    .rout  (tbl_out)
  );

  // Bypass a same-cycle write to the slot being loaded so the registered
  // selector never lags the table by an extra cycle.
  always_comb begin
    sel_next = tbl_sel;
    out_next = tbl_out;
    if (cfg_we && (cfg_addr == slot_next)) begin
      sel_next = cfg_sel;
      out_next = cfg_out_dest;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    slot_next  = slot_idx;
    skip_now   = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      slot_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = WAIT_FIRST;
          slot_next  = '0;
        end
        WAIT_FIRST: begin
          // A matching beat in the timeout cycle takes priority over the skip.
          if (match)
            state_next = mon_tlast ? ADVANCE : IN_PACKET;
          else if (timeout_hit) begin
            state_next = ADVANCE;
            skip_now   = 1'b1;
          end
        end
        IN_PACKET: begin
          if (match && mon_tlast)
            state_next = ADVANCE;
        end
        ADVANCE: begin
          state_next = WAIT_FIRST;
          slot_next  = last_slot ? '0 : slot_idx + SW'(1);
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_idx     <= '0;
      selector     <= '0;
      out_dest     <= '0;
      slot_skipped <= 1'b0;
      wait_count   <= '0;
    end else begin
      slot_idx     <= slot_next;
      slot_skipped <= skip_now;
      if (state_next == IDLE) begin
        selector <= '0;
        out_dest <= '0;
      end else begin
        selector <= sel_next;
        out_dest <= out_next;
      end
      if ((state == WAIT_FIRST) && (state_next == WAIT_FIRST)) begin
        if (wait_count != '1)
          wait_count <= wait_count + TIMEOUT_WIDTH'(1);
      end else begin
        wait_count <= '0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef SCHEDULER_STATS_EN
  logic [31:0] pkt_mem  [N_SLOTS];
  logic [15:0] skip_mem [N_SLOTS];

  // slot_skipped is high exactly during an ADVANCE caused by a timeout.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        pkt_mem[i]  <= '0;
        skip_mem[i] <= '0;
      end
      pkt_count  <= '0;
      skip_count <= '0;
    end else begin
      pkt_count  <= pkt_mem[stat_addr];
      skip_count <= skip_mem[stat_addr];
      if (state == ADVANCE) begin
        if (slot_skipped) begin
          if (skip_mem[slot_idx] != 16'hFFFF)
            skip_mem[slot_idx] <= skip_mem[slot_idx] + 16'd1;
        end else begin
          pkt_mem[slot_idx] <= pkt_mem[slot_idx] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_extractor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_extractor_scheduler
// Description : Self-checking bench for axi_stream_extractor_scheduler.
//               Directed scenarios with literal expectations, then random
//               traffic checked each cycle against a behavioural model.
//               Statistics ports exercised when SCHEDULER_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_extractor_scheduler;
  import axi_stream_scheduler_pkg::*;

  localparam int NS = 8;

  logic       clock = 1'b0;
  logic       reset, enable;
  logic [3:0] n_slots;
  logic [15:0] timeout_limit;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_sel, cfg_out_dest, mon_dest;
  logic       mon_valid, mon_ready, mon_tlast;
  logic [7:0] selector, out_dest;
  logic [2:0] slot_idx;
  logic       slot_skipped, busy;
`ifdef SCHEDULER_STATS_EN
  logic [2:0]  stat_addr;
  logic [31:0] pkt_count;
  logic [15:0] skip_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  axi_stream_extractor_scheduler #(
    .DEST_WIDTH(8), .N_SLOTS(NS), .TIMEOUT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .n_slots(n_slots),
    .timeout_limit(timeout_limit), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sel(cfg_sel), .cfg_out_dest(cfg_out_dest), .mon_dest(mon_dest),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_tlast(mon_tlast),
    .selector(selector), .out_dest(out_dest), .slot_idx(slot_idx),
    .slot_skipped(slot_skipped), .busy(busy)
`ifdef SCHEDULER_STATS_EN
    , .stat_addr(stat_addr), .pkt_count(pkt_count), .skip_count(skip_count)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  slot_entry_t m_tbl [NS];
  bit   m_active, m_inpkt, m_adv, m_skip;
  int   m_slot, m_wait;
  logic [7:0] e_sel, e_out;
`ifdef SCHEDULER_STATS_EN
  logic [31:0] m_pkt  [NS];
  logic [15:0] m_skc  [NS];
  logic [31:0] e_pkt;
  logic [15:0] e_skc;
`endif

  task automatic model_clear();
    for (int i = 0; i < NS; i++) m_tbl[i] = '0;
    m_active = 0; m_inpkt = 0; m_adv = 0; m_skip = 0; m_slot = 0; m_wait = 0;
`ifdef SCHEDULER_STATS_EN
    for (int i = 0; i < NS; i++) begin m_pkt[i] = '0; m_skc[i] = '0; end
    e_pkt = '0; e_skc = '0;
`endif
  endtask

  task automatic model_step();
    bit hit;
    int eff;
    hit = mon_valid && mon_ready && m_active && !m_adv && (mon_dest == e_sel);
    if (!reset) begin
      model_clear();
    end else begin
`ifdef SCHEDULER_STATS_EN
      e_pkt = m_pkt[stat_addr];
      e_skc = m_skc[stat_addr];
      if (m_adv) begin
        if (m_skip) begin
          if (m_skc[m_slot] != 16'hFFFF) m_skc[m_slot] = m_skc[m_slot] + 16'd1;
        end else
          m_pkt[m_slot] = m_pkt[m_slot] + 32'd1;
      end
`endif
      m_skip = 0;
      if (!enable) begin
        m_active = 0; m_slot = 0; m_inpkt = 0; m_adv = 0; m_wait = 0;
      end else if (!m_active) begin
        m_active = 1; m_slot = 0; m_inpkt = 0; m_adv = 0; m_wait = 0;
      end else if (m_adv) begin
        eff = (n_slots == 0) ? 1 : ((int'(n_slots) > NS) ? NS : int'(n_slots));
        m_slot = (m_slot + 1 >= eff) ? 0 : m_slot + 1;
        m_adv = 0; m_wait = 0;
      end else if (m_inpkt) begin
        if (hit && mon_tlast) begin m_inpkt = 0; m_adv = 1; end
      end else if (hit) begin
        if (mon_tlast) m_adv = 1; else m_inpkt = 1;
        m_wait = 0;
      end else if (timeout_limit != 0 && m_wait >= int'(timeout_limit) - 1) begin
        m_adv = 1; m_skip = 1; m_wait = 0;
      end else if (m_wait < 65535) begin
        m_wait++;
      end
      if (cfg_we) begin
        m_tbl[cfg_addr].sel      = cfg_sel;
        m_tbl[cfg_addr].out_dest = cfg_out_dest;
      end
    end
    e_sel = m_active ? m_tbl[m_slot].sel : 8'd0;
    e_out = m_active ? m_tbl[m_slot].out_dest : 8'd0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("selector",     32'(selector),     32'(e_sel));
    check("out_dest",     32'(out_dest),     32'(e_out));
    check("slot_idx",     32'(slot_idx),     32'(m_slot));
    check("slot_skipped", 32'(slot_skipped), 32'(m_skip));
    check("busy",         32'(busy),         32'(m_active));
`ifdef SCHEDULER_STATS_EN
    check("pkt_count",    pkt_count,         e_pkt);
    check("skip_count",   32'(skip_count),   32'(e_skc));
`endif
  endtask

  // Inputs change on the falling edge; model advances and compares just
  // after each rising edge.
  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic idle();
    mon_valid = 0; mon_ready = 0; mon_tlast = 0;
    step();
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    mon_valid = 1; mon_ready = 1; mon_dest = d; mon_tlast = last;
    step();
    mon_valid = 0; mon_ready = 0; mon_tlast = 0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] s, input logic [7:0] o);
    cfg_we = 1; cfg_addr = a; cfg_sel = s; cfg_out_dest = o;
    step();
    cfg_we = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 0; enable = 0; n_slots = 4'd2; timeout_limit = 16'd0;
    cfg_we = 0; cfg_addr = 0; cfg_sel = 0; cfg_out_dest = 0;
    mon_dest = 0; mon_valid = 0; mon_ready = 0; mon_tlast = 0;
`ifdef SCHEDULER_STATS_EN
    stat_addr = 0;
`endif
    model_clear();
    e_sel = 0; e_out = 0;
    @(negedge clock);

    // Reset state
    repeat (3) step();
    check("rst_selector", 32'(selector), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_slot",     32'(slot_idx), 32'd0);

    // Table {0: 3/10, 1: 5/11}, two active slots
    reset = 1;
    cfg_write(3'd0, 8'd3, 8'd10);
    cfg_write(3'd1, 8'd5, 8'd11);
    enable = 1;
    idle();
    check("en_selector", 32'(selector), 32'd3);
    check("en_out_dest", 32'(out_dest), 32'd10);
    check("en_busy",     32'(busy),     32'd1);

    // 3-beat dest 3 packet with a stray dest 7 tlast interleaved
    beat(8'd3, 1'b0);
    beat(8'd7, 1'b1);
    check("stray_selector", 32'(selector), 32'd3);
    beat(8'd3, 1'b0);
    beat(8'd3, 1'b1);
    check("adv_slot", 32'(slot_idx), 32'd0);
    idle();
    check("slot1_selector", 32'(selector), 32'd5);
    check("slot1_out_dest", 32'(out_dest), 32'd11);
    check("slot1_idx",      32'(slot_idx), 32'd1);
    beat(8'd5, 1'b1);
    idle();
    check("wrap_selector", 32'(selector), 32'd3);
    check("wrap_idx",      32'(slot_idx), 32'd0);

    // Timeout of 4 on the silent slot 1
    timeout_limit = 16'd4;
    beat(8'd3, 1'b1);
    idle();
    check("to_entry_idx", 32'(slot_idx), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("to_no_early_skip", 32'(slot_skipped), 32'd0);
    end
    idle();
    check("to_skip_pulse", 32'(slot_skipped), 32'd1);
    idle();
    check("to_skip_clear", 32'(slot_skipped), 32'd0);
    check("to_wrap_idx",   32'(slot_idx),     32'd0);

    // Matching tlast in the timeout cycle wins over the skip
    repeat (3) idle();
    beat(8'd3, 1'b1);
    check("race_no_skip", 32'(slot_skipped), 32'd0);
    idle();
    check("race_adv_idx", 32'(slot_idx), 32'd1);

    // Enable dropped mid-packet, then re-enabled
    timeout_limit = 16'd0;
    beat(8'd5, 1'b0);
    enable = 0;
    idle();
    check("dis_busy",     32'(busy),     32'd0);
    check("dis_selector", 32'(selector), 32'd0);
    enable = 1;
    idle();
    check("reen_selector", 32'(selector), 32'd3);
    check("reen_idx",      32'(slot_idx), 32'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 299) != 0);
      enable  = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 79) == 0) n_slots = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 79) == 0) timeout_limit = 16'($urandom_range(0, 6));
      cfg_we       = ($urandom_range(0, 14) == 0);
      cfg_addr     = 3'($urandom_range(0, 7));
      cfg_sel      = 8'($urandom_range(0, 3));
      cfg_out_dest = 8'($urandom);
      mon_valid    = 1'($urandom_range(0, 1));
      mon_ready    = 1'($urandom_range(0, 1));
      mon_dest     = 8'($urandom_range(0, 3));
      mon_tlast    = ($urandom_range(0, 2) == 0);
`ifdef SCHEDULER_STATS_EN
      stat_addr    = 3'($urandom_range(0, 7));
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
